// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write path.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned ZERO_REG   = 0;

    // Requester indices: ALU writeback and load/memory writeback.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the requester preferred
// under contention and moves to the losing side after every grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and next pointer value.
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = REQ_ALU;
        ptr_d   = ptr_q;
        if (en) begin
            case (req)
                2'b01: begin
                    gnt_idx = REQ_ALU;
                    gnt     = idx_to_onehot(REQ_ALU);
                end
                2'b10: begin
                    gnt_idx = REQ_MEM;
                    gnt     = idx_to_onehot(REQ_MEM);
                end
                2'b11: begin
                    gnt_idx = ptr_q;
                    gnt     = idx_to_onehot(ptr_q);
                end
                default: begin
                    gnt_idx = REQ_ALU;
                    gnt     = 2'b00;
                end
            endcase
            if (gnt != 2'b00) begin
                ptr_d = ~gnt_idx;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register; requester 0 preferred out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU and load writeback.
// The accepted write is registered so the register file can sample it on
// the following falling edge; writes to register 0 are dropped and counted.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              zero_write,
    output logic [CNT_W-1:0]  zero_write_count,
    output logic              last_grant
);

    logic [1:0]        gnt_s;
    logic              gnt_idx_s;
    logic              arb_en_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              zero_write_q, zero_write_d;
    logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;
    logic              last_grant_q, last_grant_d;

    // No grants while frozen or while reset is applied.
    assign arb_en_s = ~hold & ~reset;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en_s),
        .req     ({req1_valid, req0_valid}),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];

    // Route the winning request's payload.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        if (gnt_idx_s == REQ_MEM) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
    end

    // Next write stage: forward accepted writes, filter and count register 0.
    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        zero_write_d = 1'b0;
        zero_cnt_d   = zero_cnt_q;
        last_grant_d = last_grant_q;
        if (gnt_s != 2'b00) begin
            last_grant_d = gnt_idx_s;
            if (sel_addr_s == ADDR_W'(ZERO_REG)) begin
                zero_write_d = 1'b1;
                if (zero_cnt_q != {CNT_W{1'b1}}) begin
                    zero_cnt_d = zero_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    zero_cnt_d = zero_cnt_q;
                end
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr_s;
                wr_data_d = sel_data_s;
            end
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Output register stage; reset discards any write in flight at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_data_q    <= {DATA_W{1'b0}};
            zero_write_q <= 1'b0;
            zero_cnt_q   <= {CNT_W{1'b0}};
            last_grant_q <= REQ_ALU;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            zero_write_q <= zero_write_d;
            zero_cnt_q   <= zero_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign zero_write       = zero_write_q;
    assign zero_write_count = zero_cnt_q;
    assign last_grant       = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter with a behavioural
// model of the arbitration rules and the write stage.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        zero_write;
    logic [7:0]  zero_write_count;
    logic        last_grant;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int          prio;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_zw;
    int          e_cnt;
    logic        e_lg;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .hold             (hold),
        .req0_valid       (req0_valid),
        .req0_addr        (req0_addr),
        .req0_data        (req0_data),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_addr        (req1_addr),
        .req1_data        (req1_data),
        .req1_ready       (req1_ready),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .zero_write       (zero_write),
        .zero_write_count (zero_write_count),
        .last_grant       (last_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prio   = 0;
        e_en   = 1'b0;
        e_addr = 5'd0;
        e_data = 32'd0;
        e_zw   = 1'b0;
        e_cnt  = 0;
        e_lg   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_en"}, wr_en, e_en);
        chk({tag, ".wr_addr"}, wr_addr, e_addr);
        chk({tag, ".wr_data"}, wr_data, e_data);
        chk({tag, ".zero_write"}, zero_write, e_zw);
        chk({tag, ".zero_cnt"}, zero_write_count, e_cnt);
        chk({tag, ".last_grant"}, last_grant, e_lg);
    endtask

    // Entered just after a rising edge with inputs already driven; returns
    // the requester the model expects to be granted (-1 for none).
    task automatic cycle(input string tag, output int g);
        logic [4:0]  a;
        logic [31:0] d;
        #1;
        if (reset || hold)                g = -1;
        else if (req0_valid && req1_valid) g = prio;
        else if (req0_valid)              g = 0;
        else if (req1_valid)              g = 1;
        else                              g = -1;
        chk({tag, ".req0_ready"}, req0_ready, g == 0);
        chk({tag, ".req1_ready"}, req1_ready, g == 1);
        if (g >= 0) begin
            a = (g == 0) ? req0_addr : req1_addr;
            d = (g == 0) ? req0_data : req1_data;
            if (a == 5'd0) begin
                e_en = 1'b0;
                e_zw = 1'b1;
                if (e_cnt < 255) e_cnt++;
            end else begin
                e_en   = 1'b1;
                e_zw   = 1'b0;
                e_addr = a;
                e_data = d;
            end
            e_lg = (g == 1);
            prio = 1 - g;
        end else begin
            e_en = 1'b0;
            e_zw = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst.wr_en_async", wr_en, 1'b0);
        chk("rst.req0_ready", req0_ready, 1'b0);
        chk("rst.req1_ready", req1_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs("rst");
    endtask

    initial begin
        int g;
        int p;
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = 5'd0;
        req1_addr  = 5'd0;
        req0_data  = 32'd0;
        req1_data  = 32'd0;
        model_reset();
        do_reset();

        // Single writes from each requester
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1234;
        cycle("single0", g);
        chk("single0.addr", wr_addr, 32'd3);
        chk("single0.data", wr_data, 32'h1234);
        chk("single0.en", wr_en, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBEEF;
        cycle("single1", g);
        chk("single1.addr", wr_addr, 32'd7);
        chk("single1.data", wr_data, 32'hBEEF);
        chk("single1.en", wr_en, 1'b1);
        req1_valid = 1'b0;
        cycle("idle", g);

        // Contention alternation after reset
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA000;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB000;
        for (int i = 0; i < 4; i++) begin
            cycle("alt", g);
            chk("alt.order", last_grant, i % 2);
            if (g == 0) req0_data = req0_data + 32'd1;
            if (g == 1) req1_data = req1_data + 32'd1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Register-0 filter and counter saturation
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h5555;
        cycle("zero", g);
        chk("zero.pulse", zero_write, 1'b1);
        chk("zero.count1", zero_write_count, 32'd1);
        chk("zero.wr_en", wr_en, 1'b0);
        for (int i = 1; i < 300; i++) cycle("zero_sat", g);
        chk("zero.saturated", zero_write_count, 32'd255);
        req1_valid = 1'b0;
        cycle("zero_end", g);
        chk("zero.pulse_end", zero_write, 1'b0);

        // Hold with both requesters valid
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'hC0DE;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hD00D;
        hold = 1'b1;
        p = prio;
        for (int i = 0; i < 3; i++) begin
            cycle("hold", g);
            chk("hold.wr_en", wr_en, 1'b0);
        end
        hold = 1'b0;
        cycle("hold_rel", g);
        chk("hold_rel.first", last_grant, p);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle("idle2", g);

        // Reset while a write is in flight
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hFACE;
        cycle("midrst", g);
        chk("midrst.en_before", wr_en, 1'b1);
        req0_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("midrst.en_async", wr_en, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst.req_ready", req0_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs("midrst_after");

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            if (!req0_valid || g == 0) begin
                req0_valid = 1'($urandom_range(1, 0));
                req0_addr  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                req0_data  = $urandom;
            end
            if (!req1_valid || g == 1) begin
                req1_valid = 1'($urandom_range(1, 0));
                req1_addr  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                req1_data  = $urandom;
            end
            hold = ($urandom_range(7, 0) == 0);
            cycle("rand", g);
        end
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle("final", g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32 x 32-bit register file between two writeback sources: requester 0 (ALU writeback) and requester 1 (load/memory writeback). It performs round-robin arbitration with a valid/ready handshake and registers the winning write one cycle before the register file's falling-edge write. It filters writes to register 0 and counts them. It also honours a pipeline hold.

## Interface
**Parameters**
- DATA_W, 32: write data width.
- ADDR_W, 5: register address width.
- CNT_W, 8: width of the zero-register write counter.

**Ports**
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- hold, input, 1: pipeline freeze; while 1, no grants and no writes are issued.
- req0_valid, input, 1: ALU writeback request.
- req0_addr, input, ADDR_W: ALU destination register.
- req0_data, input, DATA_W: ALU result.
- req0_ready, output, 1: ALU request accepted this cycle.
- req1_valid, input, 1: load writeback request.
- req1_addr, input, ADDR_W: load destination register.
- req1_data, input, DATA_W: load data.
- req1_ready, output, 1: load request accepted this cycle.
- wr_en, output, 1: register file write enable (drives write_switch).
- wr_addr, output, ADDR_W: register file write address.
- wr_data, output, DATA_W: register file write data.
- zero_write, output, 1: one-cycle pulse when an accepted request targeted register 0.
- zero_write_count, output, CNT_W: saturating count of register-0 write attempts.
- last_grant, output, 1: requester index of the most recent grant.

## Operation
- **Handshake.** A transfer occurs on a rising edge when reqN_valid and reqN_ready are both 1. reqN_ready is combinational from the valids, the priority pointer and hold. The requester holds valid, addr and data stable until it is accepted.
- **Grant rule.** At most one ready per cycle, and only when hold is 0.
  - Only one requester is valid: that requester is granted.
  - Both are valid: the requester named by the priority pointer is granted.
- **Priority pointer.** After each grant, the pointer moves to the non-granted requester, so each requester waits at most one cycle under contention. The pointer is unchanged on cycles with no grant.
- **Register-0 filter.**
  - An accepted request with addr == 0 completes its handshake but is not forwarded; wr_en is 0 the next cycle.
  - zero_write pulses for that cycle.
  - zero_write_count increments and saturates at all-ones.
- **Same-address contention.** Both requesters valid for the same register is not merged: the winner writes first and the loser writes on a later grant, so the later write wins in the register file.
- **hold.** While hold is 1, both readys are 0 and wr_en is 0 on the next edge. The pointer and counter are frozen.

## Timing
- Latency is one cycle: a handshake at edge k produces wr_en, wr_addr and wr_data valid from edge k until edge k+1.
- The register file samples these outputs at the falling edge between k and k+1, so a half-cycle setup margin is guaranteed.
- Back-to-back grants are allowed every cycle; throughput is one write per cycle.
- wr_addr and wr_data hold their last values when wr_en is 0.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, zero_write 0, zero_write_count 0, last_grant 0, pointer 0 (requester 0 preferred).
- Reset asserted mid-operation:
  - wr_en clears immediately (asynchronously) and any registered write in flight is discarded.
  - Readys are forced to 0 while reset is 1.
  - The first grant is possible on the first rising edge after reset deasserts.
- Simultaneous hold and valids: no transfer. The requesters keep their valids asserted.

## Structure
- Shared package regfile_pkg holds:
  - REG_ADDR_W = 5 and REG_DATA_W = 32;
  - ZERO_REG = 0;
  - requester index constants REQ_ALU = 0 and REQ_MEM = 1.
- Sub-module rr_arbiter2 is the natural split. It covers the two-input round-robin grant and the pointer, with inputs req[1:0], en, clk, reset and outputs gnt[1:0] (one-hot) and gnt_idx.
- The top level owns the output register stage, the register-0 filter and the counter.

## Test plan
- **Reset then single writes:** after reset, req0 writes addr 3 / data 0x1234 → req0_ready = 1, and the next cycle shows wr_en = 1, wr_addr = 3, wr_data = 0x1234. req1 then writes addr 7 / data 0xBEEF with the same result on its own values.
- **Contention alternation:** both requesters valid continuously for 4 cycles after reset → grants in order 0, 1, 0, 1, and last_grant follows that sequence.
- **Register-0 filter:** req1 writes addr 0 → req1_ready = 1, zero_write pulses, zero_write_count = 1, wr_en = 0. Forcing 300 such writes leaves zero_write_count saturated at 255.
- **Hold:** hold = 1 for 3 cycles with both requesters valid → both readys are 0 and wr_en is 0. After release, the first grant goes to the requester that held pointer priority before the hold.
- **Reset mid-write:** assert reset half a cycle after a handshake to addr 5 → wr_en drops immediately and register 5 is not written. After release, all outputs are at their reset values.
